// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: pipeline results plus buffered long-op results onto one regfile write port
//
// Purpose : Drives the single register-file write port. In-order pipeline
//           results always win; mul/div results are queued in a small FIFO
//           and drained in cycles where the pipeline does not write.
//           Performs load alignment/extension and suppresses writes to x0.
// Optional: define WB_FWD_EN to expose fwd_valid_o/fwd_rd_o/fwd_dat_o, a
//           combinational copy of this cycle's selected write.
// Ports   : clk, rst_n (async active-low)
//           pipe_*_i  : pipeline result in WB (valid, rd, select, ALU, PC+4,
//                       raw load word, load addr[1:0], funct3)
//           lu_*_i/o  : long-op result handshake (valid, rd, data, ready)
//           reg_des_o, reg_des_dat_o, wr_en_o : registered regfile write
//           lq_empty_o: long-op FIFO empty
module wb_arbiter #(
  parameter int LQ_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_valid_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [1:0]      pipe_wb_sel_i,
  input  logic [XLEN-1:0] pipe_alu_i,
  input  logic [XLEN-1:0] pipe_pc4_i,
  input  logic [XLEN-1:0] pipe_ld_dat_i,
  input  logic [1:0]      pipe_ld_addr_i,
  input  logic [2:0]      pipe_funct3_i,
  input  logic            lu_valid_i,
  input  logic [4:0]      lu_rd_i,
  input  logic [XLEN-1:0] lu_dat_i,
  output logic            lu_ready_o,
  output logic [4:0]      reg_des_o,
  output logic [XLEN-1:0] reg_des_dat_o,
  output logic            wr_en_o,
`ifdef WB_FWD_EN
  output logic            fwd_valid_o,
  output logic [4:0]      fwd_rd_o,
  output logic [XLEN-1:0] fwd_dat_o,
`endif
  output logic            lq_empty_o
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(LQ_DEPTH);

  // FIFO storage; contents are only meaningful below count_q, so no reset.
  logic [4:0]      mem_rd  [LQ_DEPTH];
  logic [XLEN-1:0] mem_dat [LQ_DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      reg_des_q;
  logic [XLEN-1:0] reg_dat_q;
  logic            wr_en_q;

  logic            pipe_req, push, pop, sel_any, sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_dat, pipe_dat, ld_ext;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign lu_ready_o = (count_q != FULL);
  assign lq_empty_o = (count_q == '0);

  // Load alignment: byte at addr[1:0], half at addr[1].
  assign ld_byte = pipe_ld_dat_i[8*pipe_ld_addr_i +: 8];
  assign ld_half = pipe_ld_dat_i[16*pipe_ld_addr_i[1] +: 16];

  always_comb begin
    ld_ext = pipe_ld_dat_i;
    case (pipe_funct3_i)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = pipe_ld_dat_i;
    endcase
  end

  always_comb begin
    pipe_dat = pipe_alu_i;
    case (pipe_wb_sel_i)
      2'd1:    pipe_dat = ld_ext;
      2'd2:    pipe_dat = pipe_pc4_i;
      default: pipe_dat = pipe_alu_i;
    endcase
  end

  assign pipe_req = pipe_valid_i && (pipe_wb_sel_i != 2'd3) && (pipe_rd_i != 5'd0);

  // rd=0 long-op results are acknowledged but never stored.
  assign push = lu_valid_i && lu_ready_o && (lu_rd_i != 5'd0);

  always_comb begin
    pop     = 1'b0;
    sel_any = 1'b0;
    sel_rd  = pipe_rd_i;
    sel_dat = pipe_dat;
    if (pipe_req) begin
      sel_any = 1'b1;
    end else if (count_q != '0) begin
      pop     = 1'b1;
      sel_any = 1'b1;
      sel_rd  = mem_rd[rd_ptr_q];
      sel_dat = mem_dat[rd_ptr_q];
    end
  end

  assign sel_valid = sel_any && (sel_rd != 5'd0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr_q]  <= lu_rd_i;
      mem_dat[wr_ptr_q] <= lu_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      reg_des_q <= '0;
      reg_dat_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_en_q  <= sel_valid;
      // Index/data hold their last value in idle cycles.
      if (sel_any) begin
        reg_des_q <= sel_rd;
        reg_dat_q <= sel_dat;
      end
    end
  end

  assign reg_des_o     = reg_des_q;
  assign reg_des_dat_o = reg_dat_q;
  assign wr_en_o       = wr_en_q;

`ifdef WB_FWD_EN
  assign fwd_valid_o = sel_valid;
  assign fwd_rd_o    = sel_rd;
  assign fwd_dat_o   = sel_dat;
`endif

endmodule
